stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Timekeeping core of the stopwatch: consumes the slow square-wave clocks from the clock divider, converts them to single-cycle ticks in the 100 MHz domain, and maintains an MM:SS count in BCD. It handles run/pause and manual adjust of minutes or seconds. Its digit and blank-mask outputs feed the seven-segment display multiplexer, which runs off the divider's fast clock.

## Interface
- MAX_MIN, 59, highest minute value before wrap
- MAX_SEC, 59, highest second value before wrap
- clk  in  1  100 MHz system clock
- rst  in  1  reset, synchronous, active-high
- one_hz_in  in  1  1 Hz square wave from the divider (clk domain)
- two_hz_in  in  1  2 Hz square wave from the divider (clk domain)
- blink_in  in  1  3 Hz square wave from the divider (clk domain)
- pause_p  in  1  single-cycle debounced pause pulse
- adj  in  1  debounced level; high selects adjust mode
- sel  in  1  adjust field: 0 = minutes, 1 = seconds
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits
- blank  out  4  per-digit blank mask, [3:0] = {min_tens, min_ones, sec_tens, sec_ones}
- running  out  1  high in RUN state
- wrap_p  out  1  one-cycle pulse when the count wraps from 59:59 to 00:00

## Operation
- Tick generation: each of the three inputs is registered once (x_q).
  - one_tick = one_hz_in & ~one_hz_q; two_tick is formed the same way.
  - blink_in is used as a level only.
- States: RUN, PAUSED, ADJ.
  - RUN: on one_tick, increment seconds. Seconds go 59→00 with a carry to minutes. Minutes go MAX_MIN→00. At 59:59→00:00, pulse wrap_p.
  - PAUSED: count holds; ticks are ignored.
  - ADJ: one_tick is ignored. On two_tick, increment the selected field by 1 modulo 60, with no carry into the other field and no wrap_p.
- Transitions:
  - RUN ↔ PAUSED: on pause_p while adj = 0.
  - adj = 1 from any state → ADJ. The prior RUN/PAUSED state is saved in a flag.
  - adj falling → return to the saved state.
  - pause_p is ignored in ADJ.
- blank: all zeros outside ADJ. In ADJ, the two digits of the selected field are blanked while blink_in = 0.
- sel may change during ADJ; the new field applies from the next cycle.
- BCD arithmetic only: ones digit 9→0 carries to tens; the field value never exceeds 5/9.

## Timing
- Reset state: all digits 0, blank = 0000, running = 1, wrap_p = 0, state RUN, saved flag = RUN, x_q = 0.
- rst has priority over every other input in the same cycle.
- Latency: digits update on the clk edge ending the cycle where one_tick (or two_tick) = 1, so the new value is visible 1 cycle after the divider output rises.
- wrap_p is asserted in the same cycle the digits show 00:00.
- pause_p coincident with one_tick in RUN: the tick is applied and the state becomes PAUSED.
- pause_p coincident with one_tick in PAUSED: the tick is dropped and the state becomes RUN.
- adj rising coincident with one_tick: the tick is dropped and ADJ is entered.
- One count per divider rising edge: a level held high for many cycles yields exactly one tick.
- Outputs are registered, except running, which is decoded from the state register.

## Configuration
- STOPWATCH_LAP_EN defined: adds input port lap_p (1 bit, single-cycle pulse).
  - In RUN, lap_p freezes the displayed digits while the internal count continues.
  - A second lap_p releases the freeze; the display shows the live count on the next cycle.
  - Entering ADJ releases the freeze. rst clears the freeze.
- Not defined: no lap_p port; the displayed digits always equal the internal count.

## Structure
- stopwatch_pkg holds:
  - the state enum (RUN, PAUSED, ADJ);
  - the BCD digit type (4 bits);
  - default MAX_MIN/MAX_SEC constants;
  - blank-mask bit indices.
- Sub-module bcd_mod60_counter: a two-digit BCD counter.
  - Inputs: inc, clear. Outputs: carry_out, pulsed on MAX→00.
  - Instantiated twice, for minutes and seconds.
  - In ADJ, the seconds carry is gated off.

## Test plan
- Reset, then 3 one_hz_in rising edges in RUN → 00:03, running = 1, blank = 0000.
- Preload 59:58 via ADJ, then two one_tick in RUN → 59:59, then 00:00 with wrap_p high for exactly 1 cycle.
- pause_p at 00:05, then 4 one_tick → digits stay 00:05. Second pause_p, then 1 tick → 00:06.
- adj = 1, sel = 1 at 00:58, then 3 two_tick → 00:01, minutes unchanged. With blink_in = 0, blank = 0011; with blink_in = 1, blank = 0000.
- rst asserted mid-ADJ with two_tick in the same cycle → 00:00, state RUN, blank = 0000.
- STOPWATCH_LAP_EN: lap_p at 00:10, then 5 ticks → display 00:10. lap_p again → display 00:15 the next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
//   sw_state_t : controller states (run, paused, manual adjust)
//   bcd_t      : one BCD digit
//   DEF_MAX_*  : default highest field value before wrap
//   BLK_*      : bit positions in the per-digit blank mask
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJ    = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam int DEF_MAX_MIN = 59;
    localparam int DEF_MAX_SEC = 59;

    localparam int BLK_MIN_TENS = 3;
    localparam int BLK_MIN_ONES = 2;
    localparam int BLK_SEC_TENS = 1;
    localparam int BLK_SEC_ONES = 0;

endpackage

// File: rtl/stopwatch_core_bcd_mod60_counter.sv
// bcd_mod60_counter: two-digit BCD counter that counts 00..MAX and wraps.
// Ports:
//   clk       : system clock
//   clear     : synchronous clear to 00 (highest priority)
//   inc       : count up by one this cycle
//   tens/ones : current BCD value (registered)
//   carry_out : high in the cycle an increment takes MAX -> 00, so a
//               cascaded field advances on the same edge
module bcd_mod60_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = DEF_MAX_SEC
) (
    input  logic clk,
    input  logic clear,
    input  logic inc,
    output bcd_t tens,
    output bcd_t ones,
    output logic carry_out
);

    localparam bcd_t MAX_TENS = bcd_t'(MAX / 10);
    localparam bcd_t MAX_ONES = bcd_t'(MAX % 10);

    logic at_max;

    assign at_max    = (tens == MAX_TENS) && (ones == MAX_ONES);
    assign carry_out = inc & at_max & ~clear;

    always_ff @(posedge clk) begin
        if (clear) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_max) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == 4'd9) begin
                ones <= '0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS stopwatch timekeeping with run/pause and manual adjust.
// Converts the divider's slow square waves into single-cycle ticks and keeps
// a BCD minute/second count for the seven-segment display multiplexer.
// Ports:
//   clk, rst              : system clock, synchronous active-high reset
//   one_hz_in, two_hz_in  : divider square waves; rising edges count / adjust
//   blink_in              : blink level for the field being adjusted
//   pause_p               : toggles run/pause (ignored while adjusting)
//   adj, sel              : adjust mode level, field select (0 min, 1 sec)
//   lap_p                 : lap freeze toggle (only with STOPWATCH_LAP_EN)
//   min_*/sec_*           : displayed BCD digits
//   blank                 : per-digit blank mask {mt, mo, st, so}
//   running               : high in RUN
//   wrap_p                : one-cycle pulse as the count wraps 59:59 -> 00:00
// Build option: define STOPWATCH_LAP_EN to add the lap_p freeze feature.
//
// state  | meaning
// RUN    | counting seconds on each 1 Hz tick
// PAUSED | count held, ticks ignored
// ADJ    | 2 Hz tick bumps the selected field, no carry, no wrap pulse
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = DEF_MAX_MIN,
    parameter int MAX_SEC = DEF_MAX_SEC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_hz_in,
    input  logic       two_hz_in,
    input  logic       blink_in,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       sel,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap_p,
`endif
    output bcd_t       min_tens,
    output bcd_t       min_ones,
    output bcd_t       sec_tens,
    output bcd_t       sec_ones,
    output logic [3:0] blank,
    output logic       running,
    output logic       wrap_p
);

    logic      one_q, two_q, blink_q;
    logic      one_tick, two_tick;
    sw_state_t state, state_next;
    logic      saved_run;
    logic      run_count, adj_sec, adj_min;
    logic      sec_inc, min_inc, sec_carry, min_carry;
    logic [3:0] blank_d;
    bcd_t      m_tens, m_ones, s_tens, s_ones;

    assign one_tick = one_hz_in & ~one_q;
    assign two_tick = two_hz_in & ~two_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            one_q     <= 1'b0;
            two_q     <= 1'b0;
            blink_q   <= 1'b0;
            state     <= ST_RUN;
            saved_run <= 1'b1;
            wrap_p    <= 1'b0;
            blank     <= '0;
        end else begin
            one_q   <= one_hz_in;
            two_q   <= two_hz_in;
            blink_q <= blink_in;
            state   <= state_next;
            // Remember where adjust was entered from so we can return there.
            if (state != ST_ADJ && adj)
                saved_run <= (state == ST_RUN);
            wrap_p <= run_count & min_carry;
            blank  <= blank_d;
        end
    end

    always_comb begin
        state_next = state;
        run_count  = 1'b0;
        adj_sec    = 1'b0;
        adj_min    = 1'b0;
        blank_d    = '0;
        case (state)
            ST_RUN: begin
                // adj wins over a coincident tick: the tick is dropped.
                if (adj) begin
                    state_next = ST_ADJ;
                end else begin
                    run_count = one_tick;
                    if (pause_p)
                        state_next = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (adj)
                    state_next = ST_ADJ;
                else if (pause_p)
                    state_next = ST_RUN;
            end
            ST_ADJ: begin
                adj_sec = two_tick & sel;
                adj_min = two_tick & ~sel;
                if (!adj)
                    state_next = saved_run ? ST_RUN : ST_PAUSED;
            end
            default: state_next = ST_RUN;
        endcase

        if (state_next == ST_ADJ && !blink_q) begin
            if (sel) begin
                blank_d[BLK_SEC_TENS] = 1'b1;
                blank_d[BLK_SEC_ONES] = 1'b1;
            end else begin
                blank_d[BLK_MIN_TENS] = 1'b1;
                blank_d[BLK_MIN_ONES] = 1'b1;
            end
        end
    end

    // Seconds carry only reaches minutes while running; adjust bumps one field.
    assign sec_inc = run_count | adj_sec;
    assign min_inc = (run_count & sec_carry) | adj_min;

    bcd_mod60_counter #(.MAX(MAX_SEC)) u_sec (
        .clk       (clk),
        .clear     (rst),
        .inc       (sec_inc),
        .tens      (s_tens),
        .ones      (s_ones),
        .carry_out (sec_carry)
    );

    bcd_mod60_counter #(.MAX(MAX_MIN)) u_min (
        .clk       (clk),
        .clear     (rst),
        .inc       (min_inc),
        .tens      (m_tens),
        .ones      (m_ones),
        .carry_out (min_carry)
    );

    assign running = (state == ST_RUN);

`ifdef STOPWATCH_LAP_EN
    logic frozen;
    bcd_t snap_mt, snap_mo, snap_st, snap_so;

    always_ff @(posedge clk) begin
        if (rst) begin
            frozen  <= 1'b0;
            snap_mt <= '0;
            snap_mo <= '0;
            snap_st <= '0;
            snap_so <= '0;
        end else if (state_next == ST_ADJ) begin
            frozen <= 1'b0;
        end else if (lap_p) begin
            if (frozen) begin
                frozen <= 1'b0;
            end else if (state == ST_RUN) begin
                frozen  <= 1'b1;
                snap_mt <= m_tens;
                snap_mo <= m_ones;
                snap_st <= s_tens;
                snap_so <= s_ones;
            end
        end
    end

    assign min_tens = frozen ? snap_mt : m_tens;
    assign min_ones = frozen ? snap_mo : m_ones;
    assign sec_tens = frozen ? snap_st : s_tens;
    assign sec_ones = frozen ? snap_so : s_ones;
`else
    assign min_tens = m_tens;
    assign min_ones = m_ones;
    assign sec_tens = s_tens;
    assign sec_ones = s_ones;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Testbench for stopwatch_core: table of run/pause/adjust steps plus
// hand-written corner sequences; expectations go through a scoreboard queue.
module tb_stopwatch_core;
    import stopwatch_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       one_hz_in = 1'b0, two_hz_in = 1'b0, blink_in = 1'b0;
    logic       pause_p = 1'b0, adj = 1'b0, sel = 1'b0;
`ifdef STOPWATCH_LAP_EN
    logic       lap_p = 1'b0;
`endif
    bcd_t       min_tens, min_ones, sec_tens, sec_ones;
    logic [3:0] blank;
    logic       running, wrap_p;

    stopwatch_core dut (
        .clk       (clk),
        .rst       (rst),
        .one_hz_in (one_hz_in),
        .two_hz_in (two_hz_in),
        .blink_in  (blink_in),
        .pause_p   (pause_p),
        .adj       (adj),
        .sel       (sel),
`ifdef STOPWATCH_LAP_EN
        .lap_p     (lap_p),
`endif
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .blank     (blank),
        .running   (running),
        .wrap_p    (wrap_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       pause;
        logic       adj;
        logic       sel;
        logic       blink;
        int         n_one;
        int         n_two;
        logic [15:0] digits;
        logic [3:0] blank;
        logic       running;
    } vec_t;

    typedef struct {
        string      name;
        logic [15:0] digits;
        logic [3:0] blank;
        logic       running;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[19];

    function automatic vec_t mk(string n, logic p, logic a, logic s, logic b,
                                int o, int t, logic [15:0] d, logic [3:0] bl, logic r);
        vec_t v;
        v.name = n; v.pause = p; v.adj = a; v.sel = s; v.blink = b;
        v.n_one = o; v.n_two = t; v.digits = d; v.blank = bl; v.running = r;
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_one();
        one_hz_in = 1'b1; idle(4);
        one_hz_in = 1'b0; idle(4);
    endtask

    task automatic pulse_two();
        two_hz_in = 1'b1; idle(4);
        two_hz_in = 1'b0; idle(4);
    endtask

    task automatic push(input string n, input logic [15:0] d, input logic [3:0] bl,
                        input logic r, input logic w);
        exp_t e;
        e.name = n; e.digits = d; e.blank = bl; e.running = r; e.wrap = w;
        sb.push_back(e);
    endtask

    // Called at a falling edge: compare the DUT against the oldest expectation.
    task automatic check_pop();
        exp_t e;
        logic [15:0] got;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: queue empty at time %0t", $time);
            return;
        end
        e = sb.pop_front();
        got = {min_tens, min_ones, sec_tens, sec_ones};
        n_cmp++;
        if (got !== e.digits) begin
            n_bad++;
            $display("FAIL %s digits: got %h expected %h", e.name, got, e.digits);
        end
        n_cmp++;
        if (blank !== e.blank) begin
            n_bad++;
            $display("FAIL %s blank: got %b expected %b", e.name, blank, e.blank);
        end
        n_cmp++;
        if (running !== e.running) begin
            n_bad++;
            $display("FAIL %s running: got %b expected %b", e.name, running, e.running);
        end
        n_cmp++;
        if (wrap_p !== e.wrap) begin
            n_bad++;
            $display("FAIL %s wrap_p: got %b expected %b", e.name, wrap_p, e.wrap);
        end
    endtask

    task automatic apply(input vec_t v);
        adj = v.adj; sel = v.sel; blink_in = v.blink;
        idle(2);
        if (v.pause) begin
            pause_p = 1'b1; idle(1); pause_p = 1'b0;
        end
        repeat (v.n_one) pulse_one();
        repeat (v.n_two) pulse_two();
        idle(3);
        push(v.name, v.digits, v.blank, v.running, 1'b0);
        @(negedge clk);
        check_pop();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: bench did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //             name             pause adj sel blk one two  digits    blank    run
        vecs[0]  = mk("run3",            0,   0,  0,  0,  3,  0, 16'h0003, 4'b0000, 1);
        vecs[1]  = mk("pause",           1,   0,  0,  0,  0,  0, 16'h0003, 4'b0000, 0);
        vecs[2]  = mk("paused_ticks",    0,   0,  0,  0,  4,  0, 16'h0003, 4'b0000, 0);
        vecs[3]  = mk("resume",          1,   0,  0,  0,  2,  0, 16'h0005, 4'b0000, 1);
        vecs[4]  = mk("pause_at5",       1,   0,  0,  0,  4,  0, 16'h0005, 4'b0000, 0);
        vecs[5]  = mk("resume_tick",     1,   0,  0,  0,  1,  0, 16'h0006, 4'b0000, 1);
        vecs[6]  = mk("adj_sec_fill",    0,   1,  1,  0,  0, 52, 16'h0058, 4'b0011, 0);
        vecs[7]  = mk("adj_ignore_one",  0,   1,  1,  0,  3,  0, 16'h0058, 4'b0011, 0);
        vecs[8]  = mk("adj_sec_wrap",    0,   1,  1,  0,  0,  3, 16'h0001, 4'b0011, 0);
        vecs[9]  = mk("adj_blink_hi",    0,   1,  1,  1,  0,  0, 16'h0001, 4'b0000, 0);
        vecs[10] = mk("adj_min",         0,   1,  0,  0,  0, 59, 16'h5901, 4'b1100, 0);
        vecs[11] = mk("adj_sec_to58",    0,   1,  1,  0,  0, 57, 16'h5958, 4'b0011, 0);
        vecs[12] = mk("adj_pause_ign",   1,   1,  1,  1,  0,  0, 16'h5958, 4'b0000, 0);
        vecs[13] = mk("adj_exit_run",    0,   0,  0,  0,  0,  0, 16'h5958, 4'b0000, 1);
        vecs[14] = mk("tick_5959",       0,   0,  0,  0,  1,  0, 16'h5959, 4'b0000, 1);
        vecs[15] = mk("pause_from_run",  1,   0,  0,  0,  0,  0, 16'h0000, 4'b0000, 0);
        vecs[16] = mk("adj_from_paused", 0,   1,  0,  0,  0,  1, 16'h0100, 4'b1100, 0);
        vecs[17] = mk("adj_exit_paused", 0,   0,  0,  0,  0,  0, 16'h0100, 4'b0000, 0);
        vecs[18] = mk("paused_resume",   1,   0,  0,  0,  1,  0, 16'h0101, 4'b0000, 1);

        idle(3);
        rst = 1'b0;
        @(negedge clk);
        push("reset", 16'h0000, 4'b0000, 1'b1, 1'b0);
        check_pop();

        for (int i = 0; i < 15; i++) apply(vecs[i]);

        // 59:59 -> 00:00 with a single-cycle wrap pulse.
        one_hz_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        push("wrap_edge", 16'h0000, 4'b0000, 1'b1, 1'b1);
        check_pop();
        @(negedge clk);
        push("wrap_after", 16'h0000, 4'b0000, 1'b1, 1'b0);
        check_pop();
        one_hz_in = 1'b0;
        idle(4);

        for (int i = 15; i < 19; i++) apply(vecs[i]);

        // pause_p with a tick in RUN: tick counts, then paused.
        one_hz_in = 1'b1; pause_p = 1'b1; idle(1); pause_p = 1'b0;
        idle(3); one_hz_in = 1'b0; idle(4);
        push("pause_tick_run", 16'h0102, 4'b0000, 1'b0, 1'b0);
        @(negedge clk); check_pop();

        // pause_p with a tick in PAUSED: tick dropped, running again.
        one_hz_in = 1'b1; pause_p = 1'b1; idle(1); pause_p = 1'b0;
        idle(3); one_hz_in = 1'b0; idle(4);
        push("pause_tick_paused", 16'h0102, 4'b0000, 1'b1, 1'b0);
        @(negedge clk); check_pop();

        // adj rising with a tick: tick dropped, adjust entered.
        sel = 1'b1; blink_in = 1'b1; idle(2);
        one_hz_in = 1'b1; adj = 1'b1; idle(4); one_hz_in = 1'b0; idle(4);
        push("adj_rise_tick", 16'h0102, 4'b0000, 1'b0, 1'b0);
        @(negedge clk); check_pop();

        // Advance seconds in adjust, then reset with a coincident 2 Hz tick.
        blink_in = 1'b0;
        pulse_two(); pulse_two();
        push("pre_rst", 16'h0104, 4'b0011, 1'b0, 1'b0);
        @(negedge clk); check_pop();
        @(posedge clk); #1;
        two_hz_in = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        push("rst_in_adj", 16'h0000, 4'b0000, 1'b1, 1'b0);
        check_pop();
        adj = 1'b0; two_hz_in = 1'b0;
        idle(4);
        push("rst_settled", 16'h0000, 4'b0000, 1'b1, 1'b0);
        @(negedge clk); check_pop();

`ifdef STOPWATCH_LAP_EN
        repeat (10) pulse_one();
        lap_p = 1'b1; idle(1); lap_p = 1'b0;
        repeat (5) pulse_one();
        push("lap_frozen", 16'h0010, 4'b0000, 1'b1, 1'b0);
        @(negedge clk); check_pop();
        lap_p = 1'b1; idle(1); lap_p = 1'b0;
        @(negedge clk);
        push("lap_release", 16'h0015, 4'b0000, 1'b1, 1'b0);
        check_pop();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
